alu_pipe_ody: RTL

ALU_PIPE_ODY -- requirements
Module: alu_pipe_ody

---
 rtl/alu_pipe_pkg.sv | 19 +
 rtl/alu_pipe_core.sv | 48 ++++
 rtl/alu_pipe_ody.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode and flag definitions for the alu_pipe_ody pipeline.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AVG  = 3'b000,  // (X+Y)/2
    OP_SUM2 = 3'b001,  // (X+Y)*2
    OP_XHY  = 3'b010,  // X/2+Y
    OP_XYH  = 3'b011,  // X-Y/2
    OP_NAND = 3'b100,
    OP_NOTX = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational W+2-bit signed compute for one operand bundle.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [2:0]   sel_i,
  output logic [W+1:0] res_o
);

  localparam int FW = W + 2;

  // Halving that rounds toward zero: bias negatives by one before the shift.
  function automatic logic signed [FW-1:0] half_tz(input logic signed [FW-1:0] a);
    logic signed [FW-1:0] t;
    t = a + $signed({{(FW-1){1'b0}}, a[FW-1]});
    return t >>> 1;
  endfunction

  logic signed [FW-1:0] xs;
  logic signed [FW-1:0] ys;
  logic [W-1:0]         bw;

  assign xs = $signed({{2{x_i[W-1]}}, x_i});
  assign ys = $signed({{2{y_i[W-1]}}, y_i});

  always_comb begin
    bw    = '0;
    res_o = '0;
    case (sel_i)
      OP_AVG:  res_o = half_tz(xs + ys);
      OP_SUM2: res_o = (xs + ys) <<< 1;
      OP_XHY:  res_o = half_tz(xs) + ys;
      OP_XYH:  res_o = xs - half_tz(ys);
      OP_NAND: bw = ~(x_i & y_i);
      OP_NOTX: bw = ~x_i;
      OP_NOR:  bw = ~(x_i | y_i);
      OP_XOR:  bw = x_i ^ y_i;
      default: bw = '0;
    endcase
    if (sel_i[2]) begin
      res_o = {{2{bw[W-1]}}, bw};
    end
  end

endmodule

// File: rtl/alu_pipe_ody.sv
// Two-stage valid/ready ALU pipeline. Define ALU_PIPE_SAT_EN to clamp
// out-of-range results to the OW limits instead of wrapping.
module alu_pipe_ody
  import alu_pipe_pkg::*;
#(
  parameter int W  = 4,
  parameter int OW = W + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [2:0]    sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] result,
  output logic [2:0]    flags
);

  localparam int FW = W + 2;

  logic          s1_valid_q;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [2:0]    sel_q;
  logic          out_valid_q;
  logic [OW-1:0] result_q;
  logic [2:0]    flags_q;

  logic          s1_advance;
  logic          in_fire;
  logic [FW-1:0] full;
  logic [FW-OW:0] top_bits;
  logic          ovf;
  logic [OW-1:0] result_d;
  logic [2:0]    flags_d;

  assign s1_advance = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign in_fire    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        x_q   <= x;
        y_q   <= y;
        sel_q <= sel;
      end
    end
  end

  alu_pipe_core #(.W(W)) u_core (
    .x_i   (x_q),
    .y_i   (y_q),
    .sel_i (sel_q),
    .res_o (full)
  );

  // Value fits in OW bits only if every bit from OW-1 upward matches the sign.
  assign top_bits = full[FW-1:OW-1];
  assign ovf      = ~((&top_bits) | ~(|top_bits));

  always_comb begin
    result_d = full[OW-1:0];
`ifdef ALU_PIPE_SAT_EN
    if (ovf) begin
      result_d = full[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
`endif
    flags_d            = '0;
    flags_d[FLAG_OVF]  = ovf;
    flags_d[FLAG_NEG]  = result_d[OW-1];
    flags_d[FLAG_ZERO] = ~(|result_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (s1_advance) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
